// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-index compare on the full 32-bit address, so wrapped PCs land out of range.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr >> WORD_SHIFT) < depth;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Output register plus one-entry skid slot for fetched instructions, with flush.
module fetch_skid_buffer
  import imem_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_entry,
  input  logic         out_ready,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic         skid_valid
);

  logic         out_valid_q, out_valid_d;
  fetch_entry_t out_entry_q, out_entry_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t skid_entry_q, skid_entry_d;
  logic         out_free;

  assign out_free = !out_valid_q || out_ready;

  // The skid always drains ahead of newly returned data so ordering is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_entry_d  = out_entry_q;
    skid_valid_d = skid_valid_q;
    skid_entry_d = skid_entry_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_entry_d  = skid_entry_q;
        skid_valid_d = in_valid;
        if (in_valid) begin
          skid_entry_d = in_entry;
        end
      end else begin
        out_valid_d = in_valid;
        if (in_valid) begin
          out_entry_d = in_entry;
        end
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_entry_d = in_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_entry_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      skid_valid_q <= skid_valid_d;
      skid_entry_q <= skid_entry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_entry  = out_entry_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Program counter and fetch sequencer for a single-port instruction memory
// shared with a program loader; delivers instructions over valid/ready.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 128,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        load_active,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic        busy
);

  state_t       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inflight_valid_q, inflight_valid_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         flush;
  logic         issue;
  logic         pc_in_range;
  logic         load_in_range;
  logic         redirect_misaligned;
  logic         out_blocked;
  logic         skid_valid;
  fetch_entry_t ret_entry;
  fetch_entry_t out_entry;

  assign pc_in_range         = addr_in_range(pc_q, DEPTH);
  assign load_in_range       = addr_in_range(load_addr, DEPTH);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign out_blocked         = out_valid && !out_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    flush      = 1'b0;
    issue      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    load_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_active) begin
          state_d = ST_LOAD;
        end else if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
          fault_d = 1'b0;
          flush   = 1'b1;
        end
      end

      ST_LOAD: begin
        mem_addr  = load_addr;
        mem_wdata = load_data;
        if (load_active && load_we) begin
          if (load_in_range) begin
            mem_we = 1'b1;
          end else begin
            load_err = 1'b1;
          end
        end
        if (!load_active) begin
          state_d = ST_IDLE;
        end
      end

      // Priority: stop, then redirect, then range fault, then issue.
      ST_FETCH: begin
        if (stop) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_misaligned) begin
            state_d    = ST_HALT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!pc_in_range) begin
          state_d    = ST_HALT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
        end else if (!skid_valid && !(inflight_valid_q && out_blocked)) begin
          issue    = 1'b1;
          mem_re   = 1'b1;
          mem_addr = pc_q;
          pc_d     = pc_q + 32'(WORD_BYTES);
        end
      end

      ST_HALT: begin
        if (load_active) begin
          state_d = ST_LOAD;
        end else if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
          fault_d = 1'b0;
          flush   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    inflight_valid_d = issue;
    inflight_pc_d    = issue ? pc_q : inflight_pc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      pc_q             <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      fault_q          <= 1'b0;
      fault_pc_q       <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      fault_q          <= fault_d;
      fault_pc_q       <= fault_pc_d;
    end
  end

  // Read data is tagged with the PC captured when the read was issued.
  assign ret_entry.pc    = inflight_pc_q;
  assign ret_entry.instr = mem_rdata;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (inflight_valid_q),
    .in_entry   (ret_entry),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_entry  (out_entry),
    .skid_valid (skid_valid)
  );

  assign out_instr = out_entry.instr;
  assign out_pc    = out_entry.pc;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a memory model and an expected-delivery queue.
module tb_imem_fetch_ctrl;
  import imem_ctrl_pkg::*;

  localparam int unsigned DEPTH    = 128;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] END_ADDR = 32'h200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start, stop, redirect_valid;
  logic [31:0] redirect_pc;
  logic        load_active, load_we;
  logic [31:0] load_addr, load_data;
  logic        load_err, mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fetch_entry_t     exp_q[$];
  fetch_entry_t     mon_entry;
  logic [31:0]      ref_word [DEPTH];
  logic [31:0]      mem_array [DEPTH];
  logic [DEPTH-1:0] mem_written = '0;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load_active    (load_active),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_err       (load_err),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] default_word(input int unsigned idx);
    return 32'hC000_0000 | 32'(idx);
  endfunction

  // Single-port memory with a registered read; unwritten words hold a fixed pattern.
  always @(posedge clk) begin
    if (mem_we) begin
      mem_array[mem_addr[8:2]]   <= mem_wdata;
      mem_written[mem_addr[8:2]] <= 1'b1;
    end
    if (mem_re) begin
      mem_rdata <= mem_written[mem_addr[8:2]] ? mem_array[mem_addr[8:2]]
                                              : default_word(32'(mem_addr[8:2]));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic rv, input logic [31:0] rpc,
                               input logic la, input logic lw, input logic [31:0] ladr,
                               input logic [31:0] ldat, input logic rdy);
    start          = st;
    stop           = sp;
    redirect_valid = rv;
    redirect_pc    = rpc;
    load_active    = la;
    load_we        = lw;
    load_addr      = ladr;
    load_data      = ldat;
    out_ready      = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pushExpected(input int unsigned first, input int unsigned last);
    fetch_entry_t e;
    for (int unsigned i = first; i <= last; i++) begin
      e.pc    = 32'(i) << 2;
      e.instr = ref_word[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic waitOutPc(input logic [31:0] pc, input int budget, input string tag);
    int n = 0;
    while (!(out_valid && out_pc == pc) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (out_valid && out_pc == pc) else begin
      errors++;
      $error("[TB] FAIL %s: timed out, observed out_pc=%h expected out_pc=%h", tag, out_pc, pc);
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("mem_re_we_exclusive", 32'(mem_re && mem_we), 32'd0);
      if (mem_re) begin
        checkOutput("issue_addr_in_range", 32'(mem_addr < END_ADDR), 32'd1);
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_delivery: observed out_pc=%h expected no delivery", out_pc);
        end
        if (exp_q.size() > 0) begin
          mon_entry = exp_q.pop_front();
          checkOutput("sb_out_pc", out_pc, mon_entry.pc);
          checkOutput("sb_out_instr", out_instr, mon_entry.instr);
        end
      end
    end
  end

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ref_word[i] = default_word(i);
    end
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 0);

    // Reset state
    #3 reset = 1'b0;
    #10;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_pc", out_pc, 0);
    checkOutput("rst_out_instr", out_instr, 0);
    checkOutput("rst_mem_re", 32'(mem_re), 0);
    checkOutput("rst_mem_we", 32'(mem_we), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_fault_pc", fault_pc, 0);
    checkOutput("rst_load_err", 32'(load_err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    @(negedge clk) reset = 1'b1;
    step();

    // Load words 0..3 through the loader port
    applyStimulus(0, 0, 0, '0, 1, 0, '0, '0, 0);
    step();
    checkOutput("load_busy", 32'(busy), 1);
    for (int unsigned i = 0; i < 4; i++) begin
      ref_word[i] = 32'hA0 + 32'(i);
      applyStimulus(0, 0, 0, '0, 1, 1, 32'(i) << 2, ref_word[i], 0);
      settle();
      checkOutput("load_mem_we", 32'(mem_we), 1);
      checkOutput("load_mem_addr", mem_addr, 32'(i) << 2);
      checkOutput("load_mem_wdata", mem_wdata, ref_word[i]);
      step();
    end
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 0);
    step();
    checkOutput("load_release_idle", 32'(busy), 0);

    // Start and stream 0,4,8,12 back to back
    applyStimulus(1, 0, 0, '0, 0, 0, '0, '0, 1);
    pushExpected(0, 3);
    step();
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    settle();
    checkOutput("first_issue_re", 32'(mem_re), 1);
    checkOutput("first_issue_addr", mem_addr, RESET_PC);
    checkOutput("fetch_busy", 32'(busy), 1);
    step();
    checkOutput("latency_edge2_valid", 32'(out_valid), 0);
    step();
    checkOutput("latency_edge3_valid", 32'(out_valid), 1);
    checkOutput("stream_pc0", out_pc, 32'h0);
    step();
    checkOutput("stream_pc4", out_pc, 32'h4);
    step();
    checkOutput("stream_pc8", out_pc, 32'h8);
    step();
    checkOutput("stream_pc12", out_pc, 32'hC);
    checkOutput("stream_valid12", 32'(out_valid), 1);

    // Redirect to 8 while 0x10 is in flight; 12 still hands off this cycle
    applyStimulus(0, 0, 1, 32'h8, 0, 0, '0, '0, 1);
    pushExpected(2, 8);
    settle();
    checkOutput("redirect_no_issue", 32'(mem_re), 0);
    step();
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    checkOutput("redirect_squash_valid", 32'(out_valid), 0);
    settle();
    checkOutput("redirect_resume_re", 32'(mem_re), 1);
    checkOutput("redirect_resume_addr", mem_addr, 32'h8);

    // Backpressure for three cycles at out_pc 0x10
    waitOutPc(32'h10, 20, "wait_pc10");
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput("hold_out_pc", out_pc, 32'h10);
      checkOutput("hold_out_instr", out_instr, ref_word[4]);
      checkOutput("hold_out_valid", 32'(out_valid), 1);
      checkOutput("hold_no_issue", 32'(mem_re), 0);
      step();
    end
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);

    // Stop once 0x20 is on the output; it still completes its handshake
    waitOutPc(32'h20, 30, "wait_pc20");
    applyStimulus(0, 1, 0, '0, 0, 0, '0, '0, 1);
    step();
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    checkOutput("stop_idle", 32'(busy), 0);
    checkOutput("stop_flush_valid", 32'(out_valid), 0);
    checkOutput("stop_queue_drained", 32'(exp_q.size()), 0);

    // Misaligned redirect halts with a fault
    applyStimulus(1, 0, 0, '0, 0, 0, '0, '0, 1);
    step();
    applyStimulus(0, 0, 1, 32'h6, 0, 0, '0, '0, 1);
    step();
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    checkOutput("misalign_fault", 32'(fault), 1);
    checkOutput("misalign_fault_pc", fault_pc, 32'h6);
    checkOutput("misalign_busy", 32'(busy), 1);
    checkOutput("misalign_out_valid", 32'(out_valid), 0);
    settle();
    checkOutput("halt_no_issue", 32'(mem_re), 0);
    step();
    checkOutput("halt_still_no_issue", 32'(mem_re), 0);

    // Restart from HALT and run off the end of memory
    applyStimulus(1, 0, 0, '0, 0, 0, '0, '0, 1);
    pushExpected(0, DEPTH - 1);
    step();
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    checkOutput("restart_fault_cleared", 32'(fault), 0);
    settle();
    checkOutput("restart_issue_addr", mem_addr, RESET_PC);
    begin
      int n = 0;
      while (!fault && n < 400) begin
        step();
        n++;
      end
    end
    checkOutput("range_fault", 32'(fault), 1);
    checkOutput("range_fault_pc", fault_pc, END_ADDR);
    checkOutput("range_busy", 32'(busy), 1);
    step();
    step();
    step();
    checkOutput("range_drained", 32'(exp_q.size()), 0);
    checkOutput("range_out_valid", 32'(out_valid), 0);
    checkOutput("range_no_issue", 32'(mem_re), 0);

    // Loader write beyond the last word is dropped and flagged
    applyStimulus(0, 0, 0, '0, 1, 0, '0, '0, 1);
    step();
    checkOutput("halt_to_load_fault_kept", 32'(fault), 1);
    applyStimulus(0, 0, 0, '0, 1, 1, END_ADDR, 32'h1234_5678, 1);
    settle();
    checkOutput("oor_load_mem_we", 32'(mem_we), 0);
    checkOutput("oor_load_err", 32'(load_err), 1);
    step();
    applyStimulus(0, 0, 0, '0, 1, 0, '0, '0, 1);
    settle();
    checkOutput("load_err_pulse_end", 32'(load_err), 0);
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    step();
    checkOutput("load_exit_idle", 32'(busy), 0);

    // Fetch ignores the loader; then reset lands mid-stream
    applyStimulus(1, 0, 0, '0, 0, 0, '0, '0, 1);
    pushExpected(0, 2);
    step();
    applyStimulus(0, 0, 0, '0, 1, 1, 32'h0, 32'hDEAD_BEEF, 1);
    settle();
    checkOutput("fetch_ignores_load_we", 32'(mem_we), 0);
    checkOutput("fetch_ignores_load_re", 32'(mem_re), 1);
    waitOutPc(32'hC, 20, "wait_pc_c");
    checkOutput("fetch_stays_fetch", 32'(busy), 1);
    applyStimulus(0, 0, 0, '0, 1, 1, 32'h0, 32'hDEAD_BEEF, 0);
    settle();
    checkOutput("pre_reset_valid", 32'(out_valid), 1);
    reset = 1'b0;
    settle();
    checkOutput("async_rst_out_valid", 32'(out_valid), 0);
    checkOutput("async_rst_out_pc", out_pc, 0);
    checkOutput("async_rst_out_instr", out_instr, 0);
    checkOutput("async_rst_mem_re", 32'(mem_re), 0);
    checkOutput("async_rst_mem_we", 32'(mem_we), 0);
    checkOutput("async_rst_mem_addr", mem_addr, 0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    checkOutput("async_rst_fault_pc", fault_pc, 0);
    checkOutput("async_rst_load_err", 32'(load_err), 0);
    checkOutput("mid_stream_queue", 32'(exp_q.size()), 0);
    applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 0);
    @(negedge clk) reset = 1'b1;
    step();
    checkOutput("post_reset_idle", 32'(busy), 0);
    checkOutput("post_reset_valid", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
